// File: rtl/reg_bank_arbiter.sv
// Two-client register bank with round-robin arbitration, one access per cycle.
// Reads return one cycle after the grant; an ungranted request simply retries next cycle.
module reg_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0,
  input  logic             we0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  input  logic             req1,
  input  logic             we1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             rid
);

  logic             last_q, last_d;
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] bank_d [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             rid_q, rid_d;

  logic             sel;
  logic             grant;
  logic             acc_we;
  logic [AW-1:0]    acc_addr;
  logic [WIDTH-1:0] acc_wdata;
  logic [WIDTH-1:0] rd_dat;

  // Under contention the winner is whoever was not granted last.
  always_comb begin
    sel   = (req0 && req1) ? ~last_q : req1;
    grant = clr && (req0 || req1);
  end

  assign gnt0      = grant && !sel;
  assign gnt1      = grant && sel;
  assign acc_we    = sel ? we1    : we0;
  assign acc_addr  = sel ? addr1  : addr0;
  assign acc_wdata = sel ? wdata1 : wdata0;

  // Addresses with no matching register read as zero.
  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (acc_addr == AW'(i)) rd_dat = bank_q[i];
    end
  end

  always_comb begin
    last_d   = last_q;
    bank_d   = bank_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rid_d    = rid_q;
    if (grant) begin
      last_d = sel;
      if (acc_we) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (acc_addr == AW'(i)) bank_d[i] = acc_wdata;
        end
      end else begin
        rdata_d  = rd_dat;
        rvalid_d = 1'b1;
        rid_d    = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      last_q   <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      last_q   <= last_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= bank_d[i];
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rid    = rid_q;

  a_gnt_onehot: assert property (@(posedge clk) !(gnt0 && gnt1));

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Two-requester controller that owns a small bank of D-flip-flop registers and shares it between two independent clients.
- Performs at most one access (read or write) per cycle, chosen by round-robin arbitration, with a one-cycle registered read return.
- Sits between the multi-register storage and the two datapath agents that load and inspect it.

Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 4, number of registers in the bank (1..2^AW).
- AW, 2, address width.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- clr  in  1  synchronous, active-low clear (clr=0 at a rising edge resets the block).
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0 write enable (1=write, 0=read).
- addr0  in  AW  requester 0 register address.
- wdata0  in  WIDTH  requester 0 write data.
- gnt0  out  1  requester 0 granted this cycle.
- req1, we1, addr1, wdata1, gnt1  as above for requester 1.
- rdata  out  WIDTH  read data return.
- rvalid  out  1  rdata valid this cycle.
- rid  out  1  requester that owns the current rdata (0 or 1).

Behaviour:
- Reset (clr=0 at an edge):
  - All bank registers, rdata, rvalid and rid go to 0.
  - Internal last-grant pointer goes to 1, so requester 0 wins the first contention.
  - gnt0 and gnt1 are forced to 0 while clr=0.
  - Reset mid-operation discards any pending read return; rvalid is 0 in the cycle after reset.
- Arbitration (combinational within a cycle, clr=1):
  - Only reqX=1: gntX=1.
  - Both requesting: grant goes to the requester that is not the last-grant pointer.
  - Neither requesting: both gnt outputs 0 and the pointer is unchanged.
  - gnt0 and gnt1 are never both 1.
  - The pointer updates to the granted index at the edge ending the grant cycle.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it samples its gnt=1.
  - The access completes at the edge ending that cycle.
  - The requester may drop req or present a new request in the next cycle.
  - No request is queued internally; an ungranted request is simply re-arbitrated next cycle.
- Write (granted, we=1):
  - bank[addr] <= wdata at the edge ending the grant cycle.
  - No read return is generated (rvalid=0 next cycle).
- Read (granted, we=0):
  - At the edge ending the grant cycle: rdata <= bank[addr], rvalid <= 1, rid <= granted index. Latency is 1 cycle.
  - rvalid is a one-cycle pulse per read grant.
  - rdata and rid hold their last values when rvalid=0.
- Ordering:
  - A write granted in cycle T is visible to a read granted in cycle T+1 or later.
  - No same-cycle read/write hazard exists, because only one access is granted per cycle.
- Out-of-range address (addr >= DEPTH):
  - The access is still granted.
  - A write is dropped and leaves the bank unchanged.
  - A read returns rdata=0 with rvalid=1.
- Fairness: under continuous requests from both sides, grants strictly alternate 0,1,0,1...; neither requester waits more than 1 cycle.
- Width rules: no arithmetic; data passes unmodified; addr is compared against DEPTH as unsigned.

Test Plan:
- Release clr, no requests for 3 cycles -> gnt0=gnt1=0, rvalid=0, rdata=0; then reading all addresses returns 0x00.
- req0 write addr=2 data=0xA5 in cycle T, req0 read addr=2 in T+1 -> gnt0=1 both cycles, rvalid=1 at T+2 with rdata=0xA5, rid=0.
- req0 and req1 both held high with reads for 6 cycles -> gnt sequence 0,1,0,1,0,1; rid of returns alternates 0,1,0,1,0,1.
- req1 alone for 2 cycles, then both request -> requester 0 wins the contested cycle (pointer=1), then requester 1.
- DEPTH=3: write 0x3C to addr=3, then read addr=3 -> granted both times, rdata=0x00 with rvalid=1, other registers unchanged.
- Read granted in cycle T and clr=0 at the edge ending T -> rvalid=0 and rdata=0 in T+1; bank fully cleared; the next contention is won by requester 0.
